packet_flit_sender: RTL and testbench

//  Packetizer at a node's network-interface injection port. Accepts one packet
//  (destination + BODY_FLITS payload words) per handshake and emits it as a

---
 rtl/noc_pkg.sv | 35 +++
 rtl/packet_flit_sender.sv | 148 ++++++++++++++
 tb/tb_packet_flit_sender.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
//  Shared definitions for the network-on-chip slice: flit type encoding,
//  packetizer FSM states, default sizing parameters and the one-hot port
//  direction constants also used by the router.
// ---------------------------------------------------------------------------
package noc_pkg;

    // Default sizing of a flit and a packet
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_BODY_FLITS = 4;

    // Two-bit flit type carried in the top bits of every flit
    typedef enum logic [1:0] {
        FT_BODY = 2'b00,
        FT_HEAD = 2'b01,
        FT_TAIL = 2'b10
    } flit_type_t;

    // Packetizer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        BODY = 2'b10
    } state_t;

    // One-hot router port directions
    localparam logic [4:0] DIR_LOCAL = 5'b00001;
    localparam logic [4:0] DIR_NORTH = 5'b00010;
    localparam logic [4:0] DIR_EAST  = 5'b00100;
    localparam logic [4:0] DIR_SOUTH = 5'b01000;
    localparam logic [4:0] DIR_WEST  = 5'b10000;

endpackage

// File: rtl/packet_flit_sender.sv
// ---------------------------------------------------------------------------
// packet_flit_sender
//  Packetizer at a node's injection port. One packet (destination plus
//  BODY_FLITS payload words) is accepted per handshake and sent as a header
//  flit followed by BODY_FLITS body flits over a valid/ready flit link.
//
//  Ports:
//   clk, rst       clock, synchronous active-high reset
//   pkt_valid_i    packet offered
//   pkt_ready_o    packet accepted when pkt_valid_i & pkt_ready_o
//   dest_i         destination of the offered packet
//   payload_i      body words, word 0 in the LSBs (sent first)
//   flit_o         {type[1:0], data[DATA_W-1:0]}
//   flit_valid_o   flit_o valid
//   flit_ready_i   downstream accepts; transfer = valid & ready
//   count_o        index of the flit on flit_o (0 = header)
//   busy_o         packet in flight
//
//  Configuration macro PKT_SEND_B2B_EN: when defined, a new packet can be
//  accepted in the same cycle the tail flit transfers, so packets stream
//  without a bubble. pkt_ready_o then depends combinationally on
//  flit_ready_i. When undefined, pkt_ready_o is a pure decode of the state
//  register and one idle cycle separates consecutive packets.
// ---------------------------------------------------------------------------
module packet_flit_sender
    import noc_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BODY_FLITS = DEF_BODY_FLITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid_i,
    output logic                         pkt_ready_o,
    input  logic [ADDR_W-1:0]            dest_i,
    input  logic [BODY_FLITS*DATA_W-1:0] payload_i,
    output logic [DATA_W+1:0]            flit_o,
    output logic                         flit_valid_o,
    input  logic                         flit_ready_i,
    output logic [2:0]                   count_o,
    output logic                         busy_o
);

    localparam logic [2:0] LAST_CNT = 3'(BODY_FLITS);

    state_t                      state;
    state_t                      state_next;
    logic [2:0]                  count;
    logic [2:0]                  count_next;
    logic [ADDR_W-1:0]           dest_q;
    logic [ADDR_W-1:0]           dest_next;
    logic [BODY_FLITS*DATA_W-1:0] payload_q;
    logic [BODY_FLITS*DATA_W-1:0] payload_next;

    logic                        last_body;
    logic                        accept;
    logic [2:0]                  word_idx;
    logic [DATA_W-1:0]           body_word;

    // State, flit counter and the latched packet
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 3'd0;
            dest_q    <= '0;
            payload_q <= '0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            dest_q    <= dest_next;
            payload_q <= payload_next;
        end
    end

    // Handshake decode. In every non-IDLE state a flit is on the link, so
    // flit_ready_i alone means a transfer there.
    always_comb begin
        last_body = (state == BODY) && (count == LAST_CNT);
`ifdef PKT_SEND_B2B_EN
        pkt_ready_o = (state == IDLE) || (last_body && flit_ready_i);
`else
        pkt_ready_o = (state == IDLE);
`endif
        accept = pkt_valid_i && pkt_ready_o;
    end

    // Next-state logic; the packet inputs are sampled only on accept
    always_comb begin
        state_next   = state;
        count_next   = count;
        dest_next    = dest_q;
        payload_next = payload_q;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = HEAD;
                    count_next = 3'd0;
                end
            end
            HEAD: begin
                if (flit_ready_i) begin
                    state_next = BODY;
                    count_next = 3'd1;
                end
            end
            BODY: begin
                if (flit_ready_i) begin
                    if (count == LAST_CNT) begin
                        // Tail leaves; a back-to-back accept restarts at the header
                        state_next = accept ? HEAD : IDLE;
                        count_next = 3'd0;
                    end else begin
                        count_next = count + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 3'd0;
            end
        endcase

        if (accept) begin
            dest_next    = dest_i;
            payload_next = payload_i;
        end
    end

    // Flit assembly from registered state only, so flit_o stays stable
    // while the link stalls. Body flit n carries payload word n-1.
    always_comb begin
        word_idx  = (state == BODY) ? (count - 3'd1) : 3'd0;
        body_word = payload_q[int'(word_idx) * DATA_W +: DATA_W];

        case (state)
            HEAD:    flit_o = {FT_HEAD, DATA_W'(dest_q)};
            BODY:    flit_o = {(last_body ? FT_TAIL : FT_BODY), body_word};
            default: flit_o = '0;
        endcase

        flit_valid_o = (state != IDLE);
        busy_o       = (state != IDLE);
        count_o      = count;
    end

endmodule

// File: tb/tb_packet_flit_sender.sv
// ---------------------------------------------------------------------------
// tb_packet_flit_sender
//  Self-checking bench for packet_flit_sender. A packet-level reference model
//  tracks how many flits of the current packet are still to be sent and
//  derives the expected flit, count, valid, busy and ready every cycle.
// ---------------------------------------------------------------------------
module tb_packet_flit_sender;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int BF     = 4;
    localparam int PW     = BF * DATA_W;

`ifdef PKT_SEND_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [ADDR_W-1:0] dest;
    logic [PW-1:0]     payload;
    logic [DATA_W+1:0] flit;
    logic              flit_valid;
    logic              flit_ready;
    logic [2:0]        count;
    logic              busy;

    always #5 clk = ~clk;

    packet_flit_sender #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .BODY_FLITS (BF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid_i  (pkt_valid),
        .pkt_ready_o  (pkt_ready),
        .dest_i       (dest),
        .payload_i    (payload),
        .flit_o       (flit),
        .flit_valid_o (flit_valid),
        .flit_ready_i (flit_ready),
        .count_o      (count),
        .busy_o       (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: flits of the current packet not yet transferred
    int                rem = 0;
    logic [ADDR_W-1:0] m_dest;
    logic [DATA_W-1:0] m_words [BF];
    bit                accepted;
    int                cyc = 0;

    // Values seen in the most recent cycle
    logic [DATA_W+1:0] obs_flit;
    logic              obs_valid;
    logic [2:0]        obs_cnt;
    logic              obs_ready;

    // Log of flits that crossed the link
    logic [DATA_W+1:0] log_flit [$];
    int                log_cyc  [$];

    logic [DATA_W+1:0] ref_flits [5];
    logic [PW-1:0]     ref_payload;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cur_idx();
        return (rem == 0) ? 0 : (BF + 1 - rem);
    endfunction

    // One clock cycle: drive inputs, check the model, advance the model
    task automatic tick(input logic pv, input logic [ADDR_W-1:0] d, input logic [PW-1:0] p,
                        input logic fr, input logic r);
        logic [DATA_W+1:0] e_flit;
        logic              e_ready;
        int                idx;
        @(negedge clk);
        pkt_valid  = pv;
        dest       = d;
        payload    = p;
        flit_ready = fr;
        rst        = r;
        #1;
        idx = cur_idx();
        if (rem == 0)
            e_flit = '0;
        else if (idx == 0)
            e_flit = {2'b01, 16'(m_dest)};
        else
            e_flit = {((idx == BF) ? 2'b10 : 2'b00), m_words[idx-1]};
        e_ready = (rem == 0) || (B2B && rem == 1 && fr);

        obs_flit  = flit;
        obs_valid = flit_valid;
        obs_cnt   = count;
        obs_ready = pkt_ready;
        check("flit_valid", 32'(flit_valid), 32'(rem > 0));
        check("flit", 32'(flit), 32'(e_flit));
        check("count", 32'(count), 32'(idx));
        check("busy", 32'(busy), 32'(rem > 0));
        check("pkt_ready", 32'(pkt_ready), 32'(e_ready));

        if (!r && flit_valid && fr) begin
            log_flit.push_back(flit);
            log_cyc.push_back(cyc);
        end

        accepted = 1'b0;
        if (r) begin
            rem = 0;
        end else begin
            if (rem > 0 && fr) rem--;
            if (pv && e_ready) begin
                accepted = 1'b1;
                rem      = BF + 1;
                m_dest   = d;
                for (int k = 0; k < BF; k++) m_words[k] = p[k*DATA_W +: DATA_W];
            end
        end
        cyc++;
    endtask

    task automatic send(input logic [ADDR_W-1:0] d, input logic [PW-1:0] p, input logic fr);
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, d, p, fr, 1'b0);
            if (accepted) break;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (rem == 0) break;
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic run_to_idx(input int target);
        for (int i = 0; i < 20; i++) begin
            if (rem > 0 && cur_idx() == target) break;
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic compare_log_ref(input string tag);
        check({tag, "_len"}, 32'(log_flit.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_flit.size(); i++)
            check(tag, 32'(log_flit[i]), 32'(ref_flits[i]));
    endtask

    initial begin
        int tail_c;
        int head_c;

        ref_flits   = '{18'h10015, 18'h0A001, 18'h0A002, 18'h0A003, 18'h2A004};
        ref_payload = {16'hA004, 16'hA003, 16'hA002, 16'hA001};

        rst        = 1'b1;
        pkt_valid  = 1'b0;
        dest       = '0;
        payload    = '0;
        flit_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Idle after reset
        $display("[TB] reset and idle");
        for (int i = 0; i < 10; i++) tick(1'b0, '0, '0, 1'(i % 2), 1'b0);
        check("idle_ready", 32'(obs_ready), 32'd1);

        // Single packet with ready tied high
        $display("[TB] single packet");
        log_flit.delete(); log_cyc.delete();
        send(6'h15, ref_payload, 1'b1);
        drain();
        compare_log_ref("t2_flit");
        for (int i = 1; i < 5 && i < log_cyc.size(); i++)
            check("t2_consecutive", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        check("t2_ready_after", 32'(obs_ready), 32'd1);

        // Backpressure during body flit 2
        $display("[TB] backpressure");
        log_flit.delete(); log_cyc.delete();
        send(6'h15, ref_payload, 1'b1);
        run_to_idx(2);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0);
            check("t3_hold_flit", 32'(obs_flit), 32'h0A002);
            check("t3_hold_valid", 32'(obs_valid), 32'd1);
            check("t3_hold_count", 32'(obs_cnt), 32'd2);
        end
        drain();
        compare_log_ref("t3_flit");

        // New packet offered mid-packet is ignored
        $display("[TB] mid-packet offer");
        log_flit.delete(); log_cyc.delete();
        send(6'h15, ref_payload, 1'b1);
        run_to_idx(1);
        tick(1'b1, 6'h2A, {16'h5555, 16'h6666, 16'h7777, 16'h8888}, 1'b1, 1'b0);
        check("t4_ready_low", 32'(obs_ready), 32'd0);
        drain();
        compare_log_ref("t4_flit");

        // Reset during body flit 3
        $display("[TB] reset mid-packet");
        send(6'h15, ref_payload, 1'b1);
        run_to_idx(3);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        check("t5_valid", 32'(obs_valid), 32'd0);
        check("t5_count", 32'(obs_cnt), 32'd0);
        check("t5_ready", 32'(obs_ready), 32'd1);
        log_flit.delete(); log_cyc.delete();
        send(6'h15, ref_payload, 1'b1);
        drain();
        compare_log_ref("t5_restart");

        // Two queued packets
        $display("[TB] queued packets");
        log_flit.delete(); log_cyc.delete();
        send(6'h11, {$urandom, $urandom}, 1'b1);
        send(6'h22, {$urandom, $urandom}, 1'b1);
        drain();
        tail_c = -1;
        head_c = -1;
        for (int i = 0; i < log_flit.size(); i++) begin
            if (tail_c < 0 && log_flit[i][17:16] == 2'b10) tail_c = log_cyc[i];
            else if (tail_c >= 0 && head_c < 0 && log_flit[i][17:16] == 2'b01) head_c = log_cyc[i];
        end
        check("t6_len", 32'(log_flit.size()), 32'd10);
        check("t6_tail_to_head", 32'(head_c - tail_c), B2B ? 32'd1 : 32'd2);

        // Randomized traffic against the model
        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 1)), 6'($urandom), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
